// File: rtl/data_mem_pkg.sv
// Shared types and decode helpers for the MEM-stage data memory bridge.
// Holds the FSM state encoding, FUNCT3 opcodes and access-size decoding.
package data_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // SZ_NONE marks an illegal FUNCT3 for the requested direction.
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_NONE = 2'd3
    } size_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    function automatic size_t decode_size(input logic is_store, input logic [2:0] funct3);
        size_t size_v;
        size_v = SZ_NONE;
        if (is_store) begin
            case (funct3)
                F3_SB:   size_v = SZ_BYTE;
                F3_SH:   size_v = SZ_HALF;
                F3_SW:   size_v = SZ_WORD;
                default: size_v = SZ_NONE;
            endcase
        end else begin
            case (funct3)
                F3_LB, F3_LBU: size_v = SZ_BYTE;
                F3_LH, F3_LHU: size_v = SZ_HALF;
                F3_LW:         size_v = SZ_WORD;
                default:       size_v = SZ_NONE;
            endcase
        end
        return size_v;
    endfunction

    function automatic logic is_misaligned(input size_t size, input logic [1:0] offset);
        logic bad_v;
        case (size)
            SZ_HALF: bad_v = offset[0];
            SZ_WORD: bad_v = |offset;
            default: bad_v = 1'b0;
        endcase
        return bad_v;
    endfunction

endpackage

// File: rtl/data_mem_interface_byte_lane_aligner.sv
// Combinational lane logic: byte enables, store replication and
// left-justification of read data (addressed byte/half moved to the top).
module byte_lane_aligner
    import data_mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] read_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_lanes,
    output logic [31:0] read_left
);

    logic [4:0] shift_s;

    // Lane selection per access size; the mask clears lanes outside the addressed item.
    always_comb begin
        byte_en     = 4'b1111;
        store_lanes = store_data;
        read_left   = read_data;
        shift_s     = 5'd0;
        case (size)
            SZ_BYTE: begin
                shift_s     = {2'd3 - offset, 3'b000};
                byte_en     = 4'b0001 << offset;
                store_lanes = {4{store_data[7:0]}};
                read_left   = (read_data << shift_s) & 32'hFF00_0000;
            end
            SZ_HALF: begin
                shift_s     = {2'd2 - offset, 3'b000};
                byte_en     = 4'b0011 << offset;
                store_lanes = {2{store_data[15:0]}};
                read_left   = (read_data << shift_s) & 32'hFFFF_0000;
            end
            SZ_WORD: begin
                shift_s     = 5'd0;
                byte_en     = 4'b1111;
                store_lanes = store_data;
                read_left   = read_data;
            end
            default: begin
                shift_s     = 5'd0;
                byte_en     = 4'b0000;
                store_lanes = 32'h0000_0000;
                read_left   = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_interface.sv
// MEM-stage bridge to a handshaked word-wide data memory: validates the
// request, holds the pipeline while the access is outstanding, and times out.
module data_mem_interface
    import data_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        MEM_READ,
    input  logic        MEM_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDRESS,
    input  logic [31:0] WRITE_DATA,
    output logic [31:0] DATA_OUT,
    output logic        BUSY,
    output logic        FAULT,
    output logic [31:0] MEM_ADDRESS,
    output logic [3:0]  MEM_BYTE_EN,
    output logic [31:0] MEM_WDATA,
    output logic        MEM_RD_REQ,
    output logic        MEM_WR_REQ,
    input  logic [31:0] MEM_RDATA,
    input  logic        MEM_ACK
);

    // Last counter value of a request window; reaching it without ACK aborts.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t      state_r;
    logic [7:0]  count_r;
    size_t       size_r;
    logic [1:0]  offset_r;
    logic        is_load_r;
    logic [31:0] data_out_r;
    logic        fault_r;
    logic [31:0] mem_address_r;
    logic [3:0]  mem_byte_en_r;
    logic [31:0] mem_wdata_r;
    logic        rd_req_r;
    logic        wr_req_r;

    logic        single_req_s;
    size_t       req_size_s;
    logic        misaligned_s;
    logic        start_s;
    logic        fault_req_s;
    size_t       lane_size_s;
    logic [1:0]  lane_offset_s;
    logic [3:0]  lane_byte_en_s;
    logic [31:0] lane_store_s;
    logic [31:0] lane_read_s;

    // Request qualification in IDLE; lanes follow the live request in IDLE and the latched one otherwise.
    always_comb begin
        single_req_s = MEM_READ ^ MEM_WRITE;
        req_size_s   = decode_size(MEM_WRITE, FUNCT3);
        misaligned_s = is_misaligned(req_size_s, ADDRESS[1:0]);
        start_s      = 1'b0;
        fault_req_s  = 1'b0;
        if (state_r == ST_IDLE) begin
            start_s       = single_req_s && (req_size_s != SZ_NONE) && !misaligned_s;
            fault_req_s   = (MEM_READ && MEM_WRITE)
                          || (single_req_s && ((req_size_s == SZ_NONE) || misaligned_s));
            lane_size_s   = req_size_s;
            lane_offset_s = ADDRESS[1:0];
        end else begin
            start_s       = 1'b0;
            fault_req_s   = 1'b0;
            lane_size_s   = size_r;
            lane_offset_s = offset_r;
        end
    end

    byte_lane_aligner u_aligner (
        .size        (lane_size_s),
        .offset      (lane_offset_s),
        .store_data  (WRITE_DATA),
        .read_data   (MEM_RDATA),
        .byte_en     (lane_byte_en_s),
        .store_lanes (lane_store_s),
        .read_left   (lane_read_s)
    );

    // Stall is raised in the accepting IDLE cycle itself, so it cannot be registered.
    assign BUSY = RESET && (start_s || (state_r == ST_ACCESS));

    assign DATA_OUT    = data_out_r;
    assign FAULT       = fault_r;
    assign MEM_ADDRESS = mem_address_r;
    assign MEM_BYTE_EN = mem_byte_en_r;
    assign MEM_WDATA   = mem_wdata_r;
    assign MEM_RD_REQ  = rd_req_r;
    assign MEM_WR_REQ  = wr_req_r;

    // Access FSM with timeout counter and all registered outputs.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r       <= ST_IDLE;
            count_r       <= 8'd0;
            size_r        <= SZ_NONE;
            offset_r      <= 2'd0;
            is_load_r     <= 1'b0;
            data_out_r    <= 32'h0000_0000;
            fault_r       <= 1'b0;
            mem_address_r <= 32'h0000_0000;
            mem_byte_en_r <= 4'b0000;
            mem_wdata_r   <= 32'h0000_0000;
            rd_req_r      <= 1'b0;
            wr_req_r      <= 1'b0;
        end else begin
            fault_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        state_r       <= ST_ACCESS;
                        count_r       <= 8'd0;
                        size_r        <= req_size_s;
                        offset_r      <= ADDRESS[1:0];
                        is_load_r     <= MEM_READ;
                        mem_address_r <= {ADDRESS[31:2], 2'b00};
                        mem_byte_en_r <= MEM_READ ? 4'b1111 : lane_byte_en_s;
                        mem_wdata_r   <= MEM_READ ? 32'h0000_0000 : lane_store_s;
                        rd_req_r      <= MEM_READ;
                        wr_req_r      <= MEM_WRITE;
                    end else begin
                        fault_r <= fault_req_s;
                    end
                end
                ST_ACCESS: begin
                    if (MEM_ACK) begin
                        rd_req_r <= 1'b0;
                        wr_req_r <= 1'b0;
                        state_r  <= ST_DONE;
                        if (is_load_r) begin
                            data_out_r <= lane_read_s;
                        end else begin
                            data_out_r <= data_out_r;
                        end
                    end else if (count_r == TIMEOUT_LAST) begin
                        rd_req_r   <= 1'b0;
                        wr_req_r   <= 1'b0;
                        fault_r    <= 1'b1;
                        data_out_r <= 32'h0000_0000;
                        state_r    <= ST_DONE;
                    end else begin
                        count_r <= count_r + 8'd1;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rd_req_r <= 1'b0;
                    wr_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_interface.sv
// Directed bench for data_mem_interface: a transaction-level model predicts
// every output each cycle; literal expectations pin the model on key cases.
module tb_data_mem_interface;

    localparam int TB_TIMEOUT = 8;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        MEM_READ, MEM_WRITE, MEM_ACK;
    logic [2:0]  FUNCT3;
    logic [31:0] ADDRESS, WRITE_DATA, MEM_RDATA;
    logic [31:0] DATA_OUT, MEM_ADDRESS, MEM_WDATA;
    logic        BUSY, FAULT, MEM_RD_REQ, MEM_WR_REQ;
    logic [3:0]  MEM_BYTE_EN;

    always #5 CLK = ~CLK;

    data_mem_interface #(.TIMEOUT_CYCLES(TB_TIMEOUT)) u_dut (
        .CLK(CLK), .RESET(RESET), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .FUNCT3(FUNCT3), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .DATA_OUT(DATA_OUT), .BUSY(BUSY), .FAULT(FAULT), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_BYTE_EN(MEM_BYTE_EN), .MEM_WDATA(MEM_WDATA), .MEM_RD_REQ(MEM_RD_REQ),
        .MEM_WR_REQ(MEM_WR_REQ), .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK)
    );

    int n_vec  = 0;
    int n_fail = 0;

    logic        chk_en = 1'b0;
    logic        exp_busy = 1'b0, exp_fault = 1'b0, exp_rd = 1'b0, exp_wr = 1'b0;
    logic [31:0] exp_data = 32'h0, exp_addr = 32'h0, exp_wdata = 32'h0;
    logic [3:0]  exp_be = 4'h0;

    int          busy_cycles = 0, fault_seen = 0, rd_seen = 0, wr_seen = 0;
    logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
    logic [3:0]  last_be = 4'h0;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Model: legality, lanes and load result from plain arithmetic.
    function automatic bit m_legal(bit rd, bit wr, logic [2:0] f3, logic [31:0] a);
        int nbytes;
        if (rd == wr) return 1'b0;
        if (wr && f3 > 3'd2) return 1'b0;
        if (rd && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) return 1'b0;
        nbytes = 1 << f3[1:0];
        return (a % nbytes) == 0;
    endfunction

    function automatic logic [3:0] m_be(bit rd, logic [2:0] f3, logic [31:0] a);
        int nbytes;
        if (rd) return 4'hF;
        nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic logic [31:0] m_wdata(logic [2:0] f3, logic [31:0] wd);
        case (f3[1:0])
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(logic [2:0] f3, logic [31:0] a, logic [31:0] rdat);
        int o;
        o = a % 4;
        case (f3[1:0])
            2'd0:    return ((rdat >> (8 * o)) & 32'h0000_00FF) << 24;
            2'd1:    return ((rdat >> (8 * o)) & 32'h0000_FFFF) << 16;
            default: return rdat;
        endcase
    endfunction

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge CLK) begin
        if (chk_en) begin
            cmp("busy", 32'(BUSY), 32'(exp_busy));
            cmp("fault", 32'(FAULT), 32'(exp_fault));
            cmp("rd_req", 32'(MEM_RD_REQ), 32'(exp_rd));
            cmp("wr_req", 32'(MEM_WR_REQ), 32'(exp_wr));
            cmp("data_out", DATA_OUT, exp_data);
            if (exp_rd || exp_wr) begin
                cmp("mem_address", MEM_ADDRESS, exp_addr);
                cmp("byte_en", 32'(MEM_BYTE_EN), 32'(exp_be));
                if (exp_wr) cmp("wdata", MEM_WDATA, exp_wdata);
            end
        end
    end

    // Activity monitors used by the literal expectations.
    always @(negedge CLK) begin
        if (BUSY) busy_cycles <= busy_cycles + 1;
        if (FAULT) fault_seen <= fault_seen + 1;
        if (MEM_RD_REQ) rd_seen <= rd_seen + 1;
        if (MEM_WR_REQ) wr_seen <= wr_seen + 1;
        if (MEM_RD_REQ || MEM_WR_REQ) begin
            last_addr  <= MEM_ADDRESS;
            last_be    <= MEM_BYTE_EN;
            last_wdata <= MEM_WDATA;
        end
    end

    // One transaction; starts and ends 1 time unit after a rising edge with the DUT idle.
    task automatic run_op(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] rdat, input int ack_n);
        bit legal, timed_out;
        legal     = m_legal(rd, wr, f3, a);
        timed_out = 1'b0;
        MEM_READ = rd; MEM_WRITE = wr; FUNCT3 = f3; ADDRESS = a; WRITE_DATA = wd;
        MEM_ACK = 1'b0; MEM_RDATA = 32'h0;
        exp_busy = legal; exp_fault = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0;
        @(posedge CLK); #1;
        if (!legal) begin
            MEM_READ = 1'b0; MEM_WRITE = 1'b0;
            exp_busy = 1'b0; exp_fault = rd || wr;
            @(posedge CLK); #1;
            exp_fault = 1'b0;
            @(posedge CLK); #1;
            return;
        end
        exp_rd = rd; exp_wr = wr; exp_addr = a & 32'hFFFF_FFFC;
        exp_be = m_be(rd, f3, a); exp_wdata = m_wdata(f3, wd);
        exp_busy = 1'b1;
        for (int k = 1; k <= TB_TIMEOUT; k++) begin
            if (k == ack_n) begin
                MEM_ACK = 1'b1; MEM_RDATA = rdat;
            end else begin
                MEM_ACK = 1'b0; MEM_RDATA = rdat ^ 32'h5A5A_5A5A;
            end
            @(posedge CLK); #1;
            if (k == ack_n) break;
            if (k == TB_TIMEOUT) timed_out = 1'b1;
        end
        exp_busy = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_fault = timed_out;
        if (timed_out) exp_data = 32'h0;
        else if (rd) exp_data = m_load(f3, a, rdat);
        MEM_ACK = 1'b1; MEM_RDATA = 32'h1357_9BDF;
        @(posedge CLK); #1;
        MEM_READ = 1'b0; MEM_WRITE = 1'b0; MEM_ACK = 1'b0;
        exp_fault = 1'b0;
        @(posedge CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int b0, f0, r0, w0;
        RESET = 1'b0; MEM_READ = 1'b0; MEM_WRITE = 1'b0; MEM_ACK = 1'b0;
        FUNCT3 = 3'd0; ADDRESS = 32'h0; WRITE_DATA = 32'h0; MEM_RDATA = 32'h0;
        #2;
        cmp("reset data_out", DATA_OUT, 32'h0);
        cmp("reset busy", 32'(BUSY), 32'h0);
        cmp("reset rd_req", 32'(MEM_RD_REQ), 32'h0);
        cmp("reset byte_en", 32'(MEM_BYTE_EN), 32'h0);
        repeat (2) @(posedge CLK);
        #1 RESET = 1'b1;
        chk_en = 1'b1;
        @(posedge CLK); #1;

        // LB at 0x1003, ACK in first request cycle
        b0 = busy_cycles;
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h8033_2211, 1);
        cmp("lb data_out", DATA_OUT, 32'h8000_0000);
        cmp("lb busy cycles", 32'(busy_cycles - b0), 32'd2);
        cmp("lb mem_address", last_addr, 32'h0000_1000);
        cmp("lb byte_en", 32'(last_be), 32'h0000_000F);

        // SH at 0x1002, ACK in third request cycle
        w0 = wr_seen;
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_1002, 32'h1234_BEEF, 32'h0, 3);
        cmp("sh byte_en", 32'(last_be), 32'h0000_000C);
        cmp("sh wdata", last_wdata, 32'hBEEF_BEEF);
        cmp("sh wr_req cycles", 32'(wr_seen - w0), 32'd3);
        cmp("sh data_out kept", DATA_OUT, 32'h8000_0000);

        // LW misaligned
        b0 = busy_cycles; f0 = fault_seen; r0 = rd_seen;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_1001, 32'h0, 32'h0, 1);
        cmp("lw misaligned fault", 32'(fault_seen - f0), 32'd1);
        cmp("lw misaligned rd_req", 32'(rd_seen - r0), 32'd0);
        cmp("lw misaligned busy", 32'(busy_cycles - b0), 32'd0);

        // LHU at 0x2000, ACK in sixth request cycle
        b0 = busy_cycles;
        run_op(1'b1, 1'b0, 3'b101, 32'h0000_2000, 32'h0, 32'hAAAA_F00D, 6);
        cmp("lhu busy cycles", 32'(busy_cycles - b0), 32'd7);
        cmp("lhu data_out", DATA_OUT, 32'hF00D_0000);

        // Load with no ACK: timeout
        f0 = fault_seen; r0 = rd_seen;
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_3000, 32'h0, 32'h0, 0);
        cmp("timeout rd_req cycles", 32'(rd_seen - r0), 32'(TB_TIMEOUT));
        cmp("timeout fault", 32'(fault_seen - f0), 32'd1);
        cmp("timeout data_out", DATA_OUT, 32'h0);

        // Further lane patterns and ACK one cycle before the timeout
        run_op(1'b1, 1'b0, 3'b000, 32'h0000_1001, 32'h0, 32'h1122_3344, 2);
        cmp("lb o1 data_out", DATA_OUT, 32'h3300_0000);
        run_op(1'b1, 1'b0, 3'b001, 32'h0000_1002, 32'h0, 32'h8001_7FFF, TB_TIMEOUT - 1);
        cmp("lh o2 data_out", DATA_OUT, 32'h8001_0000);
        run_op(1'b0, 1'b1, 3'b000, 32'h0000_0013, 32'h0000_00A5, 32'h0, 1);
        cmp("sb o3 byte_en", 32'(last_be), 32'h0000_0008);
        cmp("sb o3 wdata", last_wdata, 32'hA5A5_A5A5);
        run_op(1'b0, 1'b1, 3'b010, 32'h0000_0020, 32'hCAFE_F00D, 32'h0, 2);
        run_op(1'b1, 1'b0, 3'b100, 32'h0000_0002, 32'h0, 32'hDEAD_BEEF, 1);
        cmp("lbu o2 data_out", DATA_OUT, 32'hAD00_0000);
        run_op(1'b1, 1'b0, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1);
        run_op(1'b1, 1'b0, 3'b110, 32'h0000_0000, 32'h0, 32'h0, 1);
        run_op(1'b0, 1'b1, 3'b100, 32'h0000_0000, 32'h0, 32'h0, 1);
        run_op(1'b0, 1'b1, 3'b011, 32'h0000_0000, 32'h0, 32'h0, 1);
        run_op(1'b0, 1'b1, 3'b001, 32'h0000_0001, 32'h0, 32'h0, 1);
        run_op(1'b1, 1'b1, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 1);
        run_op(1'b0, 1'b0, 3'b010, 32'h0000_0000, 32'h0, 32'h0, 1);
        cmp("illegal data_out kept", DATA_OUT, 32'hAD00_0000);

        // Reset in the second ACCESS cycle, ACK one cycle after release
        MEM_READ = 1'b1; MEM_WRITE = 1'b0; FUNCT3 = 3'b010; ADDRESS = 32'h0000_0040;
        exp_busy = 1'b1;
        @(posedge CLK); #1;
        exp_rd = 1'b1; exp_addr = 32'h0000_0040; exp_be = 4'hF;
        @(posedge CLK); #1;
        chk_en = 1'b0;
        RESET = 1'b0;
        #1;
        cmp("rst data_out", DATA_OUT, 32'h0);
        cmp("rst busy", 32'(BUSY), 32'h0);
        cmp("rst rd_req", 32'(MEM_RD_REQ), 32'h0);
        cmp("rst mem_address", MEM_ADDRESS, 32'h0);
        cmp("rst byte_en", 32'(MEM_BYTE_EN), 32'h0);
        MEM_READ = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b1;
        exp_busy = 1'b0; exp_fault = 1'b0; exp_rd = 1'b0; exp_wr = 1'b0; exp_data = 32'h0;
        chk_en = 1'b1;
        @(posedge CLK); #1;
        MEM_ACK = 1'b1; MEM_RDATA = 32'hDEAD_BEEF;
        @(posedge CLK); #1;
        MEM_ACK = 1'b0;
        cmp("post-rst ack data_out", DATA_OUT, 32'h0);
        cmp("post-rst ack rd_req", 32'(MEM_RD_REQ), 32'h0);
        run_op(1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h0, 32'h0BAD_CAFE, 1);
        cmp("post-rst lw data_out", DATA_OUT, 32'h0BAD_CAFE);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
